// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the writeback arbiter: the buffered entry
// format and the round-robin pointer advance.
package wb_arbiter_pkg;

  localparam int WB_WIDTH = 64;
  localparam int WB_DEPTH = 64;
  localparam int WB_AW    = $clog2(WB_DEPTH);

  typedef struct packed {
    logic [WB_AW-1:0]    addr;
    logic [WB_WIDTH-1:0] value;
  } wb_entry_t;

  function automatic int rr_next(input int last, input int n);
    return (last + 1) % n;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and a synchronous clear.
// The depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       din,
  output logic [width-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (cnt_q == (PW+1)'(depth));
    empty   = (cnt_q == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + (PW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (PW+1)'(1);
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_q] <= din;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs feeding up to wports registered RAM
// write ports, round-robin. WB_ARBITER_STATS_EN adds the stall_cnt output.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int width   = WB_WIDTH,
  parameter int depth   = WB_DEPTH,
  parameter int srcs    = 4,
  parameter int wports  = 2,
  parameter int fifodep = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [srcs-1:0]                      in_valid,
  output logic [srcs-1:0]                      in_ready,
  input  logic [srcs-1:0][$clog2(depth)-1:0]   in_addr,
  input  logic [srcs-1:0][width-1:0]           in_value,
  output logic [wports-1:0][$clog2(depth)-1:0] waddr,
  output logic [wports-1:0][width-1:0]         wvalue,
  output logic [wports-1:0]                    wena
`ifdef WB_ARBITER_STATS_EN
  ,
  output logic [31:0]                          stall_cnt
`endif
);

  localparam int SW = (srcs > 1) ? $clog2(srcs) : 1;
  localparam int CW = $clog2(fifodep) + 1;

  wb_entry_t         push_data [srcs];
  wb_entry_t         head      [srcs];
  logic [CW-1:0]     count     [srcs];
  logic [srcs-1:0]   full, empty, pop;

  logic [SW-1:0]     rr_q, rr_d;
  logic [wports-1:0] gnt_vld;
  logic [SW-1:0]     gnt_idx [wports];

  logic [wports-1:0]                    wena_q, wena_d;
  logic [wports-1:0][$clog2(depth)-1:0] waddr_q, waddr_d;
  logic [wports-1:0][width-1:0]         wvalue_q, wvalue_d;

  for (genvar s = 0; s < srcs; s++) begin : g_src
    assign push_data[s] = '{addr: in_addr[s], value: in_value[s]};
    // Readiness comes from the current count, so a full FIFO refuses even while popping.
    assign in_ready[s]  = rst & ~flush & (count[s] < CW'(fifodep));

    sync_fifo #(
      .width($bits(wb_entry_t)),
      .depth(fifodep)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .clear(flush),
      .push (in_valid[s] & in_ready[s]),
      .pop  (pop[s]),
      .din  (push_data[s]),
      .head (head[s]),
      .full (full[s]),
      .empty(empty[s]),
      .count(count[s])
    );

    always_comb assert (full[s] == (count[s] == CW'(fifodep)));
  end

  always_comb begin
    int n;
    int idx;
    n       = 0;
    pop     = '0;
    gnt_vld = '0;
    gnt_idx = '{default: '0};
    rr_d    = rr_q;
    for (int k = 0; k < srcs; k++) begin
      idx = (int'(rr_q) + k) % srcs;
      if (!empty[idx] && n < wports) begin
        pop[idx]     = ~flush;
        gnt_vld[n]   = 1'b1;
        gnt_idx[n]   = SW'(idx);
        rr_d         = SW'(rr_next(idx, srcs));
        n            = n + 1;
      end
    end
    if (flush) rr_d = '0;
  end

  // Ungranted ports keep their last address/value; only the enable drops.
  always_comb begin
    wena_d   = '0;
    waddr_d  = waddr_q;
    wvalue_d = wvalue_q;
    if (!flush) begin
      for (int p = 0; p < wports; p++) begin
        if (gnt_vld[p]) begin
          wena_d[p]   = 1'b1;
          waddr_d[p]  = head[gnt_idx[p]].addr;
          wvalue_d[p] = head[gnt_idx[p]].value;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q     <= '0;
      wena_q   <= '0;
      waddr_q  <= '0;
      wvalue_q <= '0;
    end else begin
      rr_q     <= rr_d;
      wena_q   <= wena_d;
      waddr_q  <= waddr_d;
      wvalue_q <= wvalue_d;
    end
  end

  assign wena   = wena_q;
  assign waddr  = waddr_q;
  assign wvalue = wvalue_q;

`ifdef WB_ARBITER_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Survives flush; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (|(in_valid & ~in_ready) && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter against a queue-based reference model.
// Define WB_ARBITER_STATS_EN to also exercise the stall counter.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int SRCS    = 4;
  localparam int WPORTS  = 2;
  localparam int FIFODEP = 4;
  localparam int AW      = WB_AW;
  localparam int W       = WB_WIDTH;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          flush;
  logic [SRCS-1:0]               in_valid;
  logic [SRCS-1:0]               in_ready;
  logic [SRCS-1:0][AW-1:0]       in_addr;
  logic [SRCS-1:0][W-1:0]        in_value;
  logic [WPORTS-1:0][AW-1:0]     waddr;
  logic [WPORTS-1:0][W-1:0]      wvalue;
  logic [WPORTS-1:0]             wena;
`ifdef WB_ARBITER_STATS_EN
  logic [31:0]                   stall_cnt;
`endif

  wb_arbiter #(
    .width(W), .depth(WB_DEPTH), .srcs(SRCS), .wports(WPORTS), .fifodep(FIFODEP)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_value(in_value),
    .waddr(waddr), .wvalue(wvalue), .wena(wena)
`ifdef WB_ARBITER_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int                n_cmp = 0;
  int                n_bad = 0;
  wb_entry_t         mq [SRCS][$];
  int                m_rr = 0;
  logic [WPORTS-1:0] m_wena = '0;
  logic [AW-1:0]     m_waddr  [WPORTS];
  logic [W-1:0]      m_wvalue [WPORTS];
  longint unsigned   m_stall = 0;
  logic [SRCS-1:0]   seen_ready;
  logic [AW-1:0]     drv_addr  [SRCS];
  logic [W-1:0]      drv_value [SRCS];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, check ready, advance model, check registered outputs.
  task automatic applyStimulus(input logic r, input logic f, input logic [SRCS-1:0] v);
    logic [SRCS-1:0] exp_ready;
    wb_entry_t       e;
    int              n, last, s;
    @(negedge clk);
    rst = r; flush = f; in_valid = v;
    for (int i = 0; i < SRCS; i++) begin
      in_addr[i]  = drv_addr[i];
      in_value[i] = drv_value[i];
    end
    #1;
    for (int i = 0; i < SRCS; i++) exp_ready[i] = r && !f && (mq[i].size() < FIFODEP);
    seen_ready = in_ready;
    checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
    if (!r) m_stall = 0;
    else if (|(v & ~exp_ready) && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (!r || f) begin
      for (int i = 0; i < SRCS; i++) mq[i].delete();
      m_rr   = 0;
      m_wena = '0;
      if (!r) for (int p = 0; p < WPORTS; p++) begin
        m_waddr[p]  = '0;
        m_wvalue[p] = '0;
      end
    end else begin
      m_wena = '0;
      n = 0;
      last = -1;
      for (int k = 0; k < SRCS; k++) begin
        s = (m_rr + k) % SRCS;
        if (n < WPORTS && mq[s].size() > 0) begin
          e = mq[s].pop_front();
          m_wena[n]   = 1'b1;
          m_waddr[n]  = e.addr;
          m_wvalue[n] = e.value;
          last = s;
          n++;
        end
      end
      if (n > 0) m_rr = (last + 1) % SRCS;
      for (int i = 0; i < SRCS; i++) begin
        if (v[i] && exp_ready[i]) begin
          e.addr  = drv_addr[i];
          e.value = drv_value[i];
          mq[i].push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput("wena", 64'(wena), 64'(m_wena));
    for (int p = 0; p < WPORTS; p++) begin
      checkOutput($sformatf("waddr[%0d]", p), 64'(waddr[p]), 64'(m_waddr[p]));
      checkOutput($sformatf("wvalue[%0d]", p), 64'(wvalue[p]), 64'(m_wvalue[p]));
    end
`ifdef WB_ARBITER_STATS_EN
    checkOutput("stall_cnt", 64'(stall_cnt), m_stall);
`endif
  endtask

  int   fair_cnt [SRCS];
  int   fair_cycles;
  bit   counting;
  bit   saw_full2;
  int   seq;
  int   post_flush_writes;
  logic [AW-1:0] ord_q [$];

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = '0; in_addr = '0; in_value = '0;
    for (int i = 0; i < SRCS; i++) begin
      drv_addr[i] = '0; drv_value[i] = '0; fair_cnt[i] = 0;
    end
    for (int p = 0; p < WPORTS; p++) begin
      m_waddr[p] = '0; m_wvalue[p] = '0;
    end

    // Reset, then a single write from source 1
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("reset_wena", 64'(wena), 64'd0);
    checkOutput("reset_waddr0", 64'(waddr[0]), 64'd0);
    checkOutput("reset_wvalue1", 64'(wvalue[1]), 64'd0);
    drv_addr[1] = 6'd5; drv_value[1] = 64'hDEAD;
    applyStimulus(1'b1, 1'b0, 4'b0010);
    checkOutput("no_bypass_wena", 64'(wena), 64'd0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("simple_wena", 64'(wena), 64'b01);
    checkOutput("simple_waddr0", 64'(waddr[0]), 64'd5);
    checkOutput("simple_wvalue0", 64'(wvalue[0]), 64'hDEAD);

    // Fairness with every source continuously valid
    applyStimulus(1'b0, 1'b0, '0);
    fair_cycles = 0; counting = 0; saw_full2 = 0; seq = 0;
    for (int c = 0; c < 140 && fair_cycles < 100; c++) begin
      for (int i = 0; i < SRCS; i++) begin
        drv_addr[i]  = AW'($urandom_range(0, WB_DEPTH - 1));
        drv_value[i] = {8'(i), 56'(seq)};
        seq++;
      end
      applyStimulus(1'b1, 1'b0, 4'hF);
      if (!seen_ready[2]) saw_full2 = 1;
      if (wena != '0) counting = 1;
      if (counting) begin
        fair_cycles++;
        for (int p = 0; p < WPORTS; p++)
          if (wena[p] && wvalue[p][63:56] < SRCS) fair_cnt[wvalue[p][63:56]]++;
      end
    end
    checkOutput("fair_window", 64'(fair_cycles), 64'd100);
    for (int i = 0; i < SRCS; i++) checkOutput($sformatf("fair_src%0d", i), 64'(fair_cnt[i]), 64'd50);
    checkOutput("backpressure_seen", 64'(saw_full2), 64'd1);

    // Per-source ordering
    applyStimulus(1'b0, 1'b0, '0);
    for (int i = 1; i <= 9; i++) begin
      drv_addr[3] = AW'(i); drv_value[3] = 64'(100 + i);
      applyStimulus(1'b1, 1'b0, (i <= 4) ? 4'b1000 : 4'b0000);
      for (int p = 0; p < WPORTS; p++) if (wena[p]) ord_q.push_back(waddr[p]);
    end
    checkOutput("order_count", 64'(ord_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < ord_q.size(); i++)
      checkOutput($sformatf("order_%0d", i), 64'(ord_q[i]), 64'(i + 1));

    // Flush with three entries buffered and two writes already registered
    applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < SRCS; i++) begin
      drv_addr[i] = AW'(10 + i); drv_value[i] = 64'(200 + i);
    end
    applyStimulus(1'b1, 1'b0, 4'hF);
    applyStimulus(1'b1, 1'b0, 4'b0001);
    checkOutput("pre_flush_wena", 64'(wena), 64'b11);
    applyStimulus(1'b1, 1'b1, 4'hF);
    checkOutput("flush_wena", 64'(wena), 64'd0);
    post_flush_writes = 0;
    repeat (5) begin
      applyStimulus(1'b1, 1'b0, '0);
      for (int p = 0; p < WPORTS; p++) if (wena[p]) post_flush_writes++;
    end
    checkOutput("post_flush_writes", 64'(post_flush_writes), 64'd0);

`ifdef WB_ARBITER_STATS_EN
    applyStimulus(1'b0, 1'b0, '0);
    repeat (7) applyStimulus(1'b1, 1'b1, 4'b0100);
    checkOutput("stall_seven", 64'(stall_cnt), 64'd7);
    applyStimulus(1'b1, 1'b1, '0);
    checkOutput("stall_after_flush", 64'(stall_cnt), 64'd7);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("stall_after_reset", 64'(stall_cnt), 64'd0);
`endif

    // Random traffic with occasional flush and reset
    applyStimulus(1'b0, 1'b0, '0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < SRCS; i++) begin
        drv_addr[i]  = AW'($urandom_range(0, WB_DEPTH - 1));
        drv_value[i] = {$urandom, $urandom};
      end
      applyStimulus(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                    ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                    SRCS'($urandom | $urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
